// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM encoding,
// register-zero constant, default mult/div latency and the load-use predicate.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } hdu_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MC_LATENCY_DEF = 4;

  // $zero is never a real dependency, so a load into it cannot cause a stall.
  function automatic logic load_use(input logic       mem_read_ex,
                                    input logic [4:0] rt_ex,
                                    input logic [4:0] rs_id,
                                    input logic [4:0] rt_id,
                                    input logic       uses_rt_id);
    return mem_read_ex && (rt_ex != REG_ZERO) &&
           ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating up-counter with increment enable and synchronous active-low clear.
module stall_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: load-use bubbles, branch/jump flushes, and an
// EX hold FSM for multi-cycle mult/div, plus a stall-cycle perf counter.
module hazard_detection_unit
  import pipe_pkg::*;
#(
  parameter int MC_LATENCY = MC_LATENCY_DEF,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_EX,
  input  logic [4:0]        RT_EX,
  input  logic [4:0]        RS_ID,
  input  logic [4:0]        RT_ID,
  input  logic              UsesRT_ID,
  input  logic              MultiCycle_EX,
  input  logic              BranchTaken_EX,
  input  logic              Jump_ID,
  output logic              PCWrite,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic              EX_Hold,
  output logic              EXMEM_Bubble,
  output logic              Busy,
  output logic [CNT_W-1:0]  StallCount,
  output logic [PERF_W-1:0] StallCycles
);

  if (MC_LATENCY < 2 || MC_LATENCY > 7) begin : g_bad_latency
    $error("hazard_detection_unit: MC_LATENCY must be in 2..7");
  end
  if ((MC_LATENCY - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("hazard_detection_unit: CNT_W too narrow for MC_LATENCY-1");
  end

  hdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic [PERF_W-1:0] perf_count;

  assign lu = load_use(MemRead_EX, RT_EX, RS_ID, RT_ID, UsesRT_ID);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EX_Hold      = 1'b0;
    EXMEM_Bubble = 1'b0;
    Busy         = 1'b0;

    case (state_q)
      RUN, MC_DONE: begin
        // MC_DONE ignores MultiCycle_EX: the finished mult/div is still flagged.
        if (state_q == MC_DONE) state_d = RUN;
        if (BranchTaken_EX) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
        end else if (MultiCycle_EX && (state_q == RUN)) begin
          PCWrite      = 1'b0;
          IFID_Write   = 1'b0;
          EX_Hold      = 1'b1;
          EXMEM_Bubble = 1'b1;
          state_d      = MC_BUSY;
          cnt_d        = CNT_W'(MC_LATENCY - 1);
        end else if (lu) begin
          PCWrite     = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
        end else if (Jump_ID) begin
          IFID_Flush = 1'b1;
        end
      end
      MC_BUSY: begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        EX_Hold      = 1'b1;
        EXMEM_Bubble = 1'b1;
        Busy         = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MC_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (!reset) begin
      PCWrite      = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Bubble  = 1'b0;
      EX_Hold      = 1'b0;
      EXMEM_Bubble = 1'b0;
      Busy         = 1'b0;
    end
  end

  assign StallCount  = reset ? cnt_q : '0;
  assign StallCycles = reset ? perf_count : '0;

  stall_perf_counter #(.W(PERF_W)) u_perf (
    .clk     (clk),
    .clear_n (reset),
    .inc     (~PCWrite),
    .count   (perf_count)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit; inputs change on the falling
// edge and combinational outputs are sampled 1ns later.
module tb_hazard_detection_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_EX, UsesRT_ID, MultiCycle_EX, BranchTaken_EX, Jump_ID;
  logic [4:0]  RT_EX, RS_ID, RT_ID;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, EXMEM_Bubble, Busy;
  logic [2:0]  StallCount;
  logic [15:0] StallCycles;
  logic [6:0]  ctl;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stalls = '0;

  hazard_detection_unit #(.MC_LATENCY(4), .CNT_W(3), .PERF_W(16)) dut (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RT_EX(RT_EX), .RS_ID(RS_ID),
    .RT_ID(RT_ID), .UsesRT_ID(UsesRT_ID), .MultiCycle_EX(MultiCycle_EX),
    .BranchTaken_EX(BranchTaken_EX), .Jump_ID(Jump_ID), .PCWrite(PCWrite),
    .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
    .EX_Hold(EX_Hold), .EXMEM_Bubble(EXMEM_Bubble), .Busy(Busy),
    .StallCount(StallCount), .StallCycles(StallCycles)
  );

  // ctl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, EXMEM_Bubble, Busy}
  assign ctl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, EXMEM_Bubble, Busy};

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset === 1'b1 && BranchTaken_EX && MultiCycle_EX)
      $display("note: BranchTaken_EX and MultiCycle_EX together at %0t (illegal input)", $time);

  task automatic drive_idle();
    MemRead_EX = 0; RT_EX = 0; RS_ID = 0; RT_ID = 0; UsesRT_ID = 0;
    MultiCycle_EX = 0; BranchTaken_EX = 0; Jump_ID = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    MultiCycle_EX = 1; MemRead_EX = 1; RT_EX = 5'd8; RS_ID = 5'd8; Jump_ID = 1;
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b1100000); end
    checks++; if (StallCount !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", StallCount); end
    checks++; if (StallCycles !== 16'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", StallCycles); end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL post_reset_ctl: got %b want %b", ctl, 7'b1100000); end
    exp_stalls = 0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    MemRead_EX = 1; RT_EX = 5'd8; RS_ID = 5'd8;
    #1;
    checks++; if (ctl !== 7'b0001000) begin errors++; $display("FAIL lu_ctl: got %b want %b", ctl, 7'b0001000); end
    checks++; if (StallCycles !== 16'd0) begin errors++; $display("FAIL lu_perf_before: got %0d want 0", StallCycles); end
    exp_stalls++;
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL lu_next_ctl: got %b want %b", ctl, 7'b1100000); end
    checks++; if (StallCycles !== 16'd1) begin errors++; $display("FAIL lu_perf_after: got %0d want 1", StallCycles); end
  endtask

  task automatic test_non_hazard();
    @(negedge clk);
    MemRead_EX = 1; RT_EX = 5'd0; RS_ID = 5'd0;
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL nh_zero_reg: got %b want %b", ctl, 7'b1100000); end
    @(negedge clk);
    MemRead_EX = 1; RT_EX = 5'd9; RS_ID = 5'd3; RT_ID = 5'd9; UsesRT_ID = 0;
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL nh_rt_unused: got %b want %b", ctl, 7'b1100000); end
    @(negedge clk);
    UsesRT_ID = 1;
    #1;
    checks++; if (ctl !== 7'b0001000) begin errors++; $display("FAIL lu_rt_used: got %b want %b", ctl, 7'b0001000); end
    exp_stalls++;
    @(negedge clk);
    MemRead_EX = 0;
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL nh_no_load: got %b want %b", ctl, 7'b1100000); end
    checks++; if (StallCycles !== exp_stalls) begin errors++; $display("FAIL nh_perf: got %0d want %0d", StallCycles, exp_stalls); end
    drive_idle();
  endtask

  task automatic test_multi_cycle();
    logic [2:0] exp_cnt [5] = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [6:0] exp_ctl [5] = '{7'b0000110, 7'b0000111, 7'b0000111, 7'b0000111, 7'b1100000};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      MultiCycle_EX = 1;
      #1;
      checks++; if (ctl !== exp_ctl[c]) begin errors++; $display("FAIL mc_ctl[%0d]: got %b want %b", c, ctl, exp_ctl[c]); end
      checks++; if (StallCount !== exp_cnt[c]) begin errors++; $display("FAIL mc_cnt[%0d]: got %0d want %0d", c, StallCount, exp_cnt[c]); end
    end
    exp_stalls += 4;
    @(negedge clk);
    MultiCycle_EX = 0;
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL mc_after_ctl: got %b want %b", ctl, 7'b1100000); end
    checks++; if (StallCycles !== exp_stalls) begin errors++; $display("FAIL mc_perf: got %0d want %0d", StallCycles, exp_stalls); end
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    BranchTaken_EX = 1; Jump_ID = 1; MemRead_EX = 1; RT_EX = 5'd8; RS_ID = 5'd8;
    #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL br_prio_ctl: got %b want %b", ctl, 7'b1111000); end
    @(negedge clk);
    drive_idle();
    BranchTaken_EX = 1; MultiCycle_EX = 1;
    #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL br_vs_mc_ctl: got %b want %b", ctl, 7'b1111000); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL br_after_ctl: got %b want %b", ctl, 7'b1100000); end
    checks++; if (StallCycles !== exp_stalls) begin errors++; $display("FAIL br_perf: got %0d want %0d", StallCycles, exp_stalls); end
  endtask

  task automatic test_jump_load_use();
    @(negedge clk);
    Jump_ID = 1; MemRead_EX = 1; RT_EX = 5'd12; RS_ID = 5'd4; RT_ID = 5'd12; UsesRT_ID = 1;
    #1;
    checks++; if (ctl !== 7'b0001000) begin errors++; $display("FAIL jmp_lu_ctl: got %b want %b", ctl, 7'b0001000); end
    exp_stalls++;
    @(negedge clk);
    MemRead_EX = 0;
    #1;
    checks++; if (ctl !== 7'b1110000) begin errors++; $display("FAIL jmp_retry_ctl: got %b want %b", ctl, 7'b1110000); end
    checks++; if (StallCycles !== exp_stalls) begin errors++; $display("FAIL jmp_perf: got %0d want %0d", StallCycles, exp_stalls); end
    drive_idle();
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    MultiCycle_EX = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (StallCount !== 3'd2 || Busy !== 1'b1) begin errors++; $display("FAIL rmh_pre: got cnt=%0d busy=%b want cnt=2 busy=1", StallCount, Busy); end
    reset = 1'b0;
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL rmh_ctl: got %b want %b", ctl, 7'b1100000); end
    checks++; if (StallCount !== 3'd0 || StallCycles !== 16'd0) begin errors++; $display("FAIL rmh_counts: got cnt=%0d perf=%0d want 0/0", StallCount, StallCycles); end
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    #1;
    checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL rmh_release_ctl: got %b want %b", ctl, 7'b1100000); end
    checks++; if (StallCount !== 3'd0 || StallCycles !== 16'd0) begin errors++; $display("FAIL rmh_release_counts: got cnt=%0d perf=%0d want 0/0", StallCount, StallCycles); end
    exp_stalls = 0;
  endtask

  task automatic test_saturation();
    // Multi-cycle held with a load-use pending: every cycle stalls, including MC_DONE.
    @(negedge clk);
    MultiCycle_EX = 1; MemRead_EX = 1; RT_EX = 5'd8; RS_ID = 5'd8;
    #1;
    checks++; if (StallCycles !== exp_stalls) begin errors++; $display("FAIL sat_start: got %0d want %0d", StallCycles, exp_stalls); end
    repeat (65534) @(negedge clk);
    #1;
    checks++; if (StallCycles !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h want fffe", StallCycles); end
    @(negedge clk);
    #1;
    checks++; if (StallCycles !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h want ffff", StallCycles); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (StallCycles !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", StallCycles); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_non_hazard();
    test_multi_cycle();
    test_branch_priority();
    test_jump_load_use();
    test_reset_mid_hold();
    test_saturation();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
